// File: rtl/bw_search_pkg.sv
// Shared types for the bandwidth search controller: FSM state encoding and
// the error cause latched for debug when a search ends without a result.
package bw_search_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L_RD,
    L_CHK,
    L_ISSUE,
    L_WAIT,
    R_RD,
    R_CHK,
    R_ISSUE,
    R_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    NO_LEFT,
    NO_RIGHT,
    TIMEOUT
  } err_cause_t;

endpackage

// File: rtl/bandwidth_search_ctrl.sv
// Walks outward from a spectral peak to find the -THRESHOLD_DB crossings on
// each side, hands each bracketing bin pair to a shared interpolator, reports bw.
module bandwidth_search_ctrl
  import bw_search_pkg::*;
#(
  parameter int FREQ_BIN_WIDTH = 9,
  parameter int ACCUM_WIDTH    = 16,
  parameter int THRESHOLD_DB   = 30,
  parameter int INTERP_TIMEOUT = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic        [FREQ_BIN_WIDTH-1:0] peak_bin_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic        [FREQ_BIN_WIDTH-1:0] f_lo_o,
  output logic        [FREQ_BIN_WIDTH-1:0] f_hi_o,
  output logic        [FREQ_BIN_WIDTH-1:0] bw_o,
  output logic                             rd_en_o,
  output logic        [FREQ_BIN_WIDTH-1:0] rd_addr_o,
  input  logic signed [ACCUM_WIDTH-1:0]    rd_data_i,
  output logic                             interp_start_o,
  output logic        [FREQ_BIN_WIDTH-1:0] interp_f1_o,
  output logic        [FREQ_BIN_WIDTH-1:0] interp_f2_o,
  output logic signed [ACCUM_WIDTH-1:0]    interp_L1_o,
  output logic signed [ACCUM_WIDTH-1:0]    interp_L2_o,
  input  logic        [FREQ_BIN_WIDTH-1:0] interp_fstar_i,
  input  logic                             interp_valid_i,
  input  logic                             interp_busy_i
);

  localparam int CNT_W = $clog2(INTERP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(INTERP_TIMEOUT - 1);
  localparam logic [FREQ_BIN_WIDTH-1:0] BIN_ONE  = FREQ_BIN_WIDTH'(1);
  localparam logic [FREQ_BIN_WIDTH-1:0] BIN_TOP  = '1;
  localparam logic signed [ACCUM_WIDTH-1:0] THR_LVL = ACCUM_WIDTH'(-THRESHOLD_DB);

  state_t                             state_q;
  err_cause_t                         cause_q;
  logic        [FREQ_BIN_WIDTH-1:0]   addr_q;
  logic        [FREQ_BIN_WIDTH-1:0]   peak_q;
  logic signed [ACCUM_WIDTH-1:0]      prev_q;
  logic        [CNT_W-1:0]            cnt_q;
  logic        [FREQ_BIN_WIDTH-1:0]   f_lo_q;
  logic        [FREQ_BIN_WIDTH-1:0]   f_hi_q;
  logic        [FREQ_BIN_WIDTH-1:0]   if1_q;
  logic        [FREQ_BIN_WIDTH-1:0]   if2_q;
  logic signed [ACCUM_WIDTH-1:0]      il1_q;
  logic signed [ACCUM_WIDTH-1:0]      il2_q;
  logic                               done_q;
  logic                               err_q;
  logic        [FREQ_BIN_WIDTH-1:0]   f_lo_res_q;
  logic        [FREQ_BIN_WIDTH-1:0]   f_hi_res_q;
  logic        [FREQ_BIN_WIDTH-1:0]   bw_q;

  logic below_thr;
  logic issuing;

  assign below_thr = rd_data_i < THR_LVL;
  assign issuing   = (state_q == L_ISSUE) || (state_q == R_ISSUE);

  assign busy_o         = (state_q != IDLE);
  assign rd_en_o        = (state_q == L_RD) || (state_q == R_RD);
  assign rd_addr_o      = addr_q;
  // The start strobe must land in the very cycle the interpolator is free.
  assign interp_start_o = issuing && !interp_busy_i;
  assign interp_f1_o    = if1_q;
  assign interp_f2_o    = if2_q;
  assign interp_L1_o    = il1_q;
  assign interp_L2_o    = il2_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign f_lo_o         = f_lo_res_q;
  assign f_hi_o         = f_hi_res_q;
  assign bw_o           = bw_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cause_q    <= ERR_NONE;
      addr_q     <= '0;
      peak_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      f_lo_q     <= '0;
      f_hi_q     <= '0;
      if1_q      <= '0;
      if2_q      <= '0;
      il1_q      <= '0;
      il2_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      f_lo_res_q <= '0;
      f_hi_res_q <= '0;
      bw_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            peak_q     <= peak_bin_i;
            prev_q     <= '0;
            cause_q    <= ERR_NONE;
            cnt_q      <= '0;
            f_lo_q     <= '0;
            f_hi_q     <= '0;
            err_q      <= 1'b0;
            f_lo_res_q <= '0;
            f_hi_res_q <= '0;
            bw_q       <= '0;
            if (peak_bin_i == '0) begin
              cause_q <= NO_LEFT;
              state_q <= DONE;
            end else begin
              addr_q  <= peak_bin_i - BIN_ONE;
              state_q <= L_RD;
            end
          end
        end

        L_RD: state_q <= L_CHK;

        L_CHK: begin
          // prev_q starts at 0 dB so a crossing at peak-1 brackets against the peak.
          if (below_thr) begin
            if1_q   <= addr_q;
            if2_q   <= addr_q + BIN_ONE;
            il1_q   <= rd_data_i;
            il2_q   <= prev_q;
            state_q <= L_ISSUE;
          end else begin
            prev_q <= rd_data_i;
            if (addr_q == '0) begin
              cause_q <= NO_LEFT;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q - BIN_ONE;
              state_q <= L_RD;
            end
          end
        end

        L_ISSUE: begin
          if (!interp_busy_i) begin
            cnt_q   <= '0;
            state_q <= L_WAIT;
          end
        end

        L_WAIT: begin
          if (interp_valid_i) begin
            f_lo_q <= interp_fstar_i;
            prev_q <= '0;
            if (peak_q == BIN_TOP) begin
              cause_q <= NO_RIGHT;
              state_q <= DONE;
            end else begin
              addr_q  <= peak_q + BIN_ONE;
              state_q <= R_RD;
            end
          end else if (cnt_q == CNT_LAST) begin
            cause_q <= TIMEOUT;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        R_RD: state_q <= R_CHK;

        R_CHK: begin
          if (below_thr) begin
            if1_q   <= addr_q - BIN_ONE;
            if2_q   <= addr_q;
            il1_q   <= prev_q;
            il2_q   <= rd_data_i;
            state_q <= R_ISSUE;
          end else begin
            prev_q <= rd_data_i;
            if (addr_q == BIN_TOP) begin
              cause_q <= NO_RIGHT;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q + BIN_ONE;
              state_q <= R_RD;
            end
          end
        end

        R_ISSUE: begin
          if (!interp_busy_i) begin
            cnt_q   <= '0;
            state_q <= R_WAIT;
          end
        end

        R_WAIT: begin
          if (interp_valid_i) begin
            f_hi_q  <= interp_fstar_i;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            cause_q <= TIMEOUT;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        DONE: begin
          done_q <= 1'b1;
          if (cause_q != ERR_NONE) begin
            err_q      <= 1'b1;
            f_lo_res_q <= '0;
            f_hi_res_q <= '0;
            bw_q       <= '0;
          end else begin
            err_q      <= 1'b0;
            f_lo_res_q <= f_lo_q;
            f_hi_res_q <= f_hi_q;
            bw_q       <= f_hi_q - f_lo_q;
          end
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bandwidth_search_ctrl.sv
// Directed bench for bandwidth_search_ctrl with a spectrum RAM model and a
// simple interpolator model that replays a table of f* answers.
module tb_bandwidth_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               start;
  logic        [8:0]  peak;
  logic               busy, done, err;
  logic        [8:0]  f_lo, f_hi, bw;
  logic               rd_en;
  logic        [8:0]  rd_addr;
  logic signed [15:0] rd_data;
  logic               istart;
  logic        [8:0]  if1, if2;
  logic signed [15:0] il1, il2;
  logic        [8:0]  ifstar;
  logic               ivalid;
  logic               ibusy;

  bandwidth_search_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .peak_bin_i(peak),
    .busy_o(busy), .done_o(done), .err_o(err),
    .f_lo_o(f_lo), .f_hi_o(f_hi), .bw_o(bw),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .interp_start_o(istart), .interp_f1_o(if1), .interp_f2_o(if2),
    .interp_L1_o(il1), .interp_L2_o(il2), .interp_fstar_i(ifstar),
    .interp_valid_i(ivalid), .interp_busy_i(ibusy)
  );

  // spectrum RAM model and read monitor
  logic signed [15:0] spec_mem [0:511];
  logic        clr;
  int          rd_cnt;
  logic [8:0]  last_addr;
  always @(posedge clk) begin
    rd_data <= spec_mem[rd_addr];
    if (clr) begin
      rd_cnt    <= 0;
      last_addr <= '0;
    end else if (rd_en) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= rd_addr;
    end
  end

  // interpolator model: valid is seen by the DUT k cycles after its start strobe
  logic [8:0]         fstar_tbl [0:3];
  bit                 interp_en;
  int                 interp_k;
  int                 start_cnt, resp_idx, cd;
  logic               mdl_valid;
  logic [8:0]         mdl_fstar;
  logic               late_valid;
  logic [8:0]         cap_f1 [0:3];
  logic [8:0]         cap_f2 [0:3];
  logic signed [15:0] cap_l1 [0:3];
  logic signed [15:0] cap_l2 [0:3];

  assign ivalid = mdl_valid | late_valid;
  assign ifstar = late_valid ? 9'd123 : mdl_fstar;

  always @(posedge clk) begin
    mdl_valid <= 1'b0;
    if (clr) begin
      start_cnt <= 0;
      resp_idx  <= 0;
      cd        <= 0;
    end else if (istart) begin
      if (start_cnt < 4) begin
        cap_f1[start_cnt] <= if1;
        cap_f2[start_cnt] <= if2;
        cap_l1[start_cnt] <= il1;
        cap_l2[start_cnt] <= il2;
      end
      start_cnt <= start_cnt + 1;
      if (interp_en) begin
        if (interp_k <= 1) begin
          mdl_valid <= 1'b1;
          mdl_fstar <= fstar_tbl[resp_idx[1:0]];
          resp_idx  <= resp_idx + 1;
        end else begin
          cd <= interp_k - 1;
        end
      end
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        mdl_valid <= 1'b1;
        mdl_fstar <= fstar_tbl[resp_idx[1:0]];
        resp_idx  <= resp_idx + 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic prep(input bit en, input int k);
    for (int i = 0; i < 512; i++) spec_mem[i] = 16'sd0;
    interp_en = en;
    interp_k  = k;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Starts a search and returns the number of cycles until done_o is seen.
  task automatic run(input logic [8:0] p, input int inject, output int cycles);
    start  = 1'b1;
    peak   = p;
    cycles = 0;
    do begin
      tick();
      cycles++;
      start = (cycles == inject);
      if (start) peak = 9'd5;
    end while (!done && cycles < 400);
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int cyc;

  initial begin
    rst = 1'b1; start = 1'b0; peak = '0; ibusy = 1'b0; late_valid = 1'b0;
    clr = 1'b0; interp_en = 1'b0; interp_k = 1;
    for (int i = 0; i < 4; i++) fstar_tbl[i] = '0;
    for (int i = 0; i < 512; i++) spec_mem[i] = 16'sd0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_bw", 32'(bw), 32'd0);
    rst = 1'b0;
    tick();

    // reference case: peak 100, k=1
    prep(1'b1, 1);
    spec_mem[99] = -16'sd10; spec_mem[98] = -16'sd40;
    spec_mem[101] = -16'sd20; spec_mem[102] = -16'sd35;
    fstar_tbl[0] = 9'd98; fstar_tbl[1] = 9'd101;
    run(9'd100, 0, cyc);
    chk("ref_err", 32'(err), 32'd0);
    chk("ref_f_lo", 32'(f_lo), 32'd98);
    chk("ref_f_hi", 32'(f_hi), 32'd101);
    chk("ref_bw", 32'(bw), 32'd3);
    chk("ref_lf1", 32'(cap_f1[0]), 32'd98);
    chk("ref_lf2", 32'(cap_f2[0]), 32'd99);
    chk("ref_ll1", 32'(cap_l1[0]), -32'sd40);
    chk("ref_ll2", 32'(cap_l2[0]), -32'sd10);
    chk("ref_rf1", 32'(cap_f1[1]), 32'd101);
    chk("ref_rf2", 32'(cap_f2[1]), 32'd102);
    chk("ref_rl1", 32'(cap_l1[1]), -32'sd20);
    chk("ref_rl2", 32'(cap_l2[1]), -32'sd35);
    chk("ref_reads", 32'(rd_cnt), 32'd4);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("result_hold", 32'(bw), 32'd3);

    // best-case latency: crossings at peak+-1, k=1 -> 2*(3+1)+2 = 10
    prep(1'b1, 1);
    spec_mem[199] = -16'sd31; spec_mem[201] = -16'sd50;
    fstar_tbl[0] = 9'd199; fstar_tbl[1] = 9'd201;
    run(9'd200, 0, cyc);
    chk("best_latency", 32'(cyc), 32'd10);
    chk("best_bw", 32'(bw), 32'd2);
    chk("best_ll2_peak", 32'(cap_l2[0]), 32'd0);
    chk("best_rl1_peak", 32'(cap_l1[1]), 32'd0);
    chk("best_rf1", 32'(cap_f1[1]), 32'd200);

    // exact -30 is not a crossing; start pulse mid-search must be ignored; k=3
    prep(1'b1, 3);
    spec_mem[299] = -16'sd30; spec_mem[298] = -16'sd31; spec_mem[301] = -16'sd31;
    fstar_tbl[0] = 9'd298; fstar_tbl[1] = 9'd301;
    run(9'd300, 4, cyc);
    chk("thr_err", 32'(err), 32'd0);
    chk("thr_lf1", 32'(cap_f1[0]), 32'd298);
    chk("thr_ll2", 32'(cap_l2[0]), -32'sd30);
    chk("thr_f_lo", 32'(f_lo), 32'd298);
    chk("thr_bw", 32'(bw), 32'd3);

    // peak 0: immediate error, no reads
    prep(1'b1, 1);
    run(9'd0, 0, cyc);
    chk("p0_latency", 32'(cyc), 32'd2);
    chk("p0_err", 32'(err), 32'd1);
    chk("p0_reads", 32'(rd_cnt), 32'd0);
    chk("p0_bw", 32'(bw), 32'd0);

    // peak 500: no right crossing up to the top bin
    prep(1'b1, 1);
    spec_mem[499] = -16'sd40;
    fstar_tbl[0] = 9'd499;
    run(9'd500, 0, cyc);
    chk("top_err", 32'(err), 32'd1);
    chk("top_reads", 32'(rd_cnt), 32'd12);
    chk("top_last_addr", 32'(last_addr), 32'd511);
    chk("top_f_lo", 32'(f_lo), 32'd0);
    chk("top_bw", 32'(bw), 32'd0);

    // interpolator busy for 5 cycles at L_ISSUE
    prep(1'b1, 1);
    spec_mem[99] = -16'sd10; spec_mem[98] = -16'sd40;
    spec_mem[101] = -16'sd20; spec_mem[102] = -16'sd35;
    fstar_tbl[0] = 9'd98; fstar_tbl[1] = 9'd101;
    ibusy = 1'b1;
    start = 1'b1; peak = 9'd100;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bsy_no_start", 32'(istart), 32'd0);
      chk("bsy_busy", 32'(busy), 32'd1);
      chk("bsy_f1", 32'(if1), 32'd98);
      chk("bsy_l2", 32'(il2), -32'sd10);
    end
    tick();
    ibusy = 1'b0;
    #1;
    chk("bsy_start_now", 32'(istart), 32'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("bsy_done", 32'(done), 32'd1);
    chk("bsy_f_hi", 32'(f_hi), 32'd101);
    chk("bsy_bw", 32'(bw), 32'd3);

    // interpolator never answers: 64 wait cycles then error (ISSUE at tick 3)
    prep(1'b0, 1);
    spec_mem[199] = -16'sd31; spec_mem[201] = -16'sd50;
    run(9'd200, 0, cyc);
    chk("to_latency", 32'(cyc), 32'd69);
    chk("to_err", 32'(err), 32'd1);
    chk("to_f_lo", 32'(f_lo), 32'd0);

    // reset during L_WAIT, then a late valid must be ignored
    prep(1'b0, 1);
    spec_mem[199] = -16'sd31; spec_mem[201] = -16'sd50;
    start = 1'b1; peak = 9'd200;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_f1", 32'(if1), 32'd0);
    chk("arst_l1", 32'(il1), 32'd0);
    chk("arst_istart", 32'(istart), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    tick();
    rst = 1'b0;
    late_valid = 1'b1;
    tick();
    late_valid = 1'b0;
    tick();
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_done", 32'(done), 32'd0);
    chk("late_f_lo", 32'(f_lo), 32'd0);
    chk("late_err", 32'(err), 32'd0);

    // recovery after reset
    prep(1'b1, 1);
    spec_mem[199] = -16'sd31; spec_mem[201] = -16'sd50;
    fstar_tbl[0] = 9'd199; fstar_tbl[1] = 9'd201;
    run(9'd200, 0, cyc);
    chk("rec_f_lo", 32'(f_lo), 32'd199);
    chk("rec_bw", 32'(bw), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
